// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RISC-V datapath (fetch/decode/execute/memory/writeback).
// Optional memory wait states are enabled by defining CTRL_MEMWAIT_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | read instruction at PC, latch IR/OldPC, PC <= PC + 4
// DECODE   | read registers, compute branch target OldPC + imm
// MEMADR   | compute load/store address rs1 + imm
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to data memory at ALUOut
// EXECR    | ALU op on rs1, rs2
// EXECI    | ALU op on rs1, imm
// ALUWB    | write ALUOut to rd
// BEQ      | compare rs1, rs2; take branch when zero
// JAL      | PC <= target, ALU computes return address OldPC + 4
// TRAP     | unsupported opcode, parked until reset
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } ctrlState_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    ctrlState_t stateQ, stateNext;
    logic       illegalQ;
    logic       pcUpdate;
    logic       branch;
    logic       memGo;

`ifdef CTRL_MEMWAIT_EN
    assign memGo = mem_ready;
`else
    // Every access completes in one cycle; mem_ready has no effect.
    assign memGo = mem_ready | 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= FETCH;
            illegalQ <= 1'b0;
        end else begin
            stateQ <= stateNext;
            if (stateNext == TRAP) illegalQ <= 1'b1;
        end
    end

    always_comb begin
        stateNext = stateQ;
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        pcUpdate  = 1'b0;
        branch    = 1'b0;
        case (stateQ)
            FETCH: begin
                mem_req   = 1'b1;
                IRWrite   = memGo;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcUpdate  = memGo;
                if (memGo) stateNext = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: stateNext = MEMADR;
                    OP_RTYPE:          stateNext = EXECR;
                    OP_ITYPE:          stateNext = EXECI;
                    OP_BEQ:            stateNext = BEQ;
                    OP_JAL:            stateNext = JAL;
                    default:           stateNext = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                stateNext = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (memGo) stateNext = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                stateNext = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = memGo;
                if (memGo) stateNext = FETCH;
            end
            EXECR: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b10;
                stateNext = ALUWB;
            end
            EXECI: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ALUOp     = 2'b10;
                stateNext = ALUWB;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                stateNext = FETCH;
            end
            BEQ: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b01;
                branch    = 1'b1;
                stateNext = FETCH;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pcUpdate  = 1'b1;
                stateNext = ALUWB;
            end
            TRAP:    stateNext = TRAP;
            default: stateNext = FETCH;
        endcase
    end

    // Immediate format follows the opcode in every state, matching the single-cycle decoder.
    always_comb begin
        case (op)
            OP_STORE: ImmSrc = 2'b01;
            OP_BEQ:   ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite = pcUpdate | (branch & zero);
    assign illegal = illegalQ;
    assign state   = stateQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, reset, trap and memory waits.
// Control outputs are packed as {mem_req,PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,RegWrite}.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                           ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5,
                           ST_EXECR = 4'd6, ST_EXECI = 4'd7, ST_ALUWB = 4'd8,
                           ST_BEQ = 4'd9, ST_JAL = 4'd10, ST_TRAP = 4'd11;

    localparam logic [13:0] C_FETCH    = 14'b11001_10_00_10_00_0;
    localparam logic [13:0] C_DECODE   = 14'b00000_00_01_01_00_0;
    localparam logic [13:0] C_MEMADR   = 14'b00000_00_10_01_00_0;
    localparam logic [13:0] C_MEMREAD  = 14'b10100_00_00_00_00_0;
    localparam logic [13:0] C_MEMWB    = 14'b00000_01_00_00_00_1;
    localparam logic [13:0] C_MEMWRITE = 14'b10110_00_00_00_00_0;
    localparam logic [13:0] C_EXECR    = 14'b00000_00_10_00_10_0;
    localparam logic [13:0] C_EXECI    = 14'b00000_00_10_01_10_0;
    localparam logic [13:0] C_ALUWB    = 14'b00000_00_00_00_00_1;
    localparam logic [13:0] C_BEQ_T    = 14'b01000_00_10_00_01_0;
    localparam logic [13:0] C_BEQ_NT   = 14'b00000_00_10_00_01_0;
    localparam logic [13:0] C_JAL      = 14'b01000_00_01_10_00_0;
    localparam logic [13:0] C_IDLE     = 14'b00000_00_00_00_00_0;
    localparam logic [13:0] C_MEMWT_HOLD  = 14'b10100_00_00_00_00_0;
    localparam logic [13:0] C_FETCH_HOLD  = 14'b10000_10_00_10_00_0;

    logic [13:0] ctl;
    assign ctl = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite};

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] expState, input logic [13:0] expCtl);
        chk({tag, ".state"}, 32'(state), 32'(expState));
        chk({tag, ".ctl"}, 32'(ctl), 32'(expCtl));
    endtask

    int irPulses;

    initial begin
        reset = 1'b1; op = 7'b0110011; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        step("rst_fetch", ST_FETCH, C_FETCH);
        chk("rst_illegal", 32'(illegal), 32'd0);
        tick(); step("r_decode", ST_DECODE, C_DECODE);
        tick(); step("r_execr", ST_EXECR, C_EXECR);
        chk("r_imm", 32'(ImmSrc), 32'd0);
        tick(); step("r_aluwb", ST_ALUWB, C_ALUWB);
        tick(); step("r_fetch", ST_FETCH, C_FETCH);

        op = 7'b0000011;
        tick(); step("lw_decode", ST_DECODE, C_DECODE);
        chk("lw_imm", 32'(ImmSrc), 32'd0);
        tick(); step("lw_memadr", ST_MEMADR, C_MEMADR);
        tick(); step("lw_memread", ST_MEMREAD, C_MEMREAD);
        tick(); step("lw_memwb", ST_MEMWB, C_MEMWB);
        tick(); step("lw_fetch", ST_FETCH, C_FETCH);

        op = 7'b0100011;
        tick(); step("sw_decode", ST_DECODE, C_DECODE);
        chk("sw_imm", 32'(ImmSrc), 32'd1);
        tick(); step("sw_memadr", ST_MEMADR, C_MEMADR);
        tick(); step("sw_memwrite", ST_MEMWRITE, C_MEMWRITE);
        tick(); step("sw_fetch", ST_FETCH, C_FETCH);

        op = 7'b0010011;
        tick(); step("i_decode", ST_DECODE, C_DECODE);
        tick(); step("i_execi", ST_EXECI, C_EXECI);
        tick(); step("i_aluwb", ST_ALUWB, C_ALUWB);
        tick(); step("i_fetch", ST_FETCH, C_FETCH);

        op = 7'b1100011; zero = 1'b1;
        tick(); step("beqt_decode", ST_DECODE, C_DECODE);
        chk("beq_imm", 32'(ImmSrc), 32'd2);
        tick(); step("beqt_beq", ST_BEQ, C_BEQ_T);
        zero = 1'b0; #1;
        chk("beq_zero_drop", 32'(PCWrite), 32'd0);
        zero = 1'b1; #1;
        chk("beq_zero_rise", 32'(PCWrite), 32'd1);
        tick(); step("beqt_fetch", ST_FETCH, C_FETCH);
        zero = 1'b0;
        tick(); step("beqn_decode", ST_DECODE, C_DECODE);
        tick(); step("beqn_beq", ST_BEQ, C_BEQ_NT);
        tick(); step("beqn_fetch", ST_FETCH, C_FETCH);

        op = 7'b1101111;
        tick(); step("jal_decode", ST_DECODE, C_DECODE);
        chk("jal_imm", 32'(ImmSrc), 32'd3);
        tick(); step("jal_jal", ST_JAL, C_JAL);
        tick(); step("jal_aluwb", ST_ALUWB, C_ALUWB);
        tick(); step("jal_fetch", ST_FETCH, C_FETCH);

        // Reset abandons a load just before its writeback.
        op = 7'b0000011;
        tick(); tick(); tick();
        step("lwab_memread", ST_MEMREAD, C_MEMREAD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        step("lwab_fetch", ST_FETCH, C_FETCH);
        chk("lwab_regwrite", 32'(RegWrite), 32'd0);

        // Reset abandons a store in address phase.
        op = 7'b0100011;
        tick(); tick();
        step("swab_memadr", ST_MEMADR, C_MEMADR);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        step("swab_fetch", ST_FETCH, C_FETCH);
        chk("swab_memwrite", 32'(MemWrite), 32'd0);

        op = 7'b0110111;
        tick(); step("trap_decode", ST_DECODE, C_DECODE);
        chk("trap_pre_illegal", 32'(illegal), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            step("trap_hold", ST_TRAP, C_IDLE);
            chk("trap_illegal", 32'(illegal), 32'd1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        step("trap_rst", ST_FETCH, C_FETCH);
        chk("trap_rst_illegal", 32'(illegal), 32'd0);

`ifdef CTRL_MEMWAIT_EN
        // Fetch stall: IRWrite must pulse exactly once.
        op = 7'b0100011; mem_ready = 1'b0; irPulses = 0;
        for (int i = 0; i < 2; i++) begin
            step("fstall_hold", ST_FETCH, C_FETCH_HOLD);
            irPulses += int'(IRWrite);
            tick();
        end
        mem_ready = 1'b1; #1;
        step("fstall_done", ST_FETCH, C_FETCH);
        irPulses += int'(IRWrite);
        tick(); step("wsw_decode", ST_DECODE, C_DECODE);
        irPulses += int'(IRWrite);
        chk("fstall_pulses", 32'(irPulses), 32'd1);
        tick(); step("wsw_memadr", ST_MEMADR, C_MEMADR);
        tick();
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            step("wsw_hold", ST_MEMWRITE, C_MEMWT_HOLD);
            tick();
        end
        mem_ready = 1'b1; #1;
        step("wsw_done", ST_MEMWRITE, C_MEMWRITE);
        tick(); step("wsw_fetch", ST_FETCH, C_FETCH);
`else
        // mem_ready is ignored: a low value must not stall any access.
        op = 7'b0100011; mem_ready = 1'b0; #1;
        step("nw_fetch", ST_FETCH, C_FETCH);
        tick(); step("nw_decode", ST_DECODE, C_DECODE);
        tick(); step("nw_memadr", ST_MEMADR, C_MEMADR);
        tick(); step("nw_memwrite", ST_MEMWRITE, C_MEMWRITE);
        tick(); step("nw_fetch2", ST_FETCH, C_FETCH);
        mem_ready = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
